// File: rtl/dcache_tag_assoc.sv
// N-way set-associative dcache tag/valid/dirty store, tree PLRU, flush sweep.
// Define DCACHE_TAG_PERF_EN to add saturating hit/miss/write-back counters.
module dcache_tag_assoc #(
    parameter  int ADDR_W   = 64,
    parameter  int INDEX_W  = 6,
    parameter  int OFFSET_W = 3,
    parameter  int WAYS     = 2,
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req,
    input  logic              req_we,
    input  logic              req_cached,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              refill,
    output logic              hit,
    output logic [WAYS-1:0]   hit_way,
    output logic              miss,
    output logic [WAYS-1:0]   victim_way,
    output logic              victim_dirty,
    output logic [TAG_W-1:0]  victim_tag,
    input  logic              flush_req,
    output logic              busy,
    output logic              wb_req,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WAYS-1:0]   wb_way,
    input  logic              wb_ack
`ifdef DCACHE_TAG_PERF_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss,
    output logic [31:0]       perf_wb
`endif
);

    localparam int SETS   = 2 ** INDEX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    typedef logic [WAY_W-1:0] way_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WB, ST_DONE} state_t;

    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   dirty_q [WAYS];
    logic [PLRU_W-1:0] plru_q  [SETS];

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] s_q, s_d;
    way_t               w_q, w_d;
    logic               wb_req_q, wb_req_d;
    logic               adv;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   atag;
    way_t               hit_w, vic, vic_inv, vic_plru;
    logic               any_inv;
    logic               refill_en, hit_upd;
    logic               unused_offset;

    assign idx  = req_addr[OFFSET_W +: INDEX_W];
    assign atag = req_addr[ADDR_W-1 -: TAG_W];
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    // Each node bit names the subtree holding the next victim.
    function automatic logic [PLRU_W-1:0] plru_touch(
        input logic [PLRU_W-1:0] p,
        input way_t              way
    );
        logic [PLRU_W-1:0] r;
        r = p;
        for (int l = 0; l < WAY_W; l++)
            for (int n = 0; n < PLRU_W; n++)
                if (n == (2 ** l) - 1 + int'(way >> (WAY_W - l)))
                    r[n] = ~way[WAY_W-1-l];
        return r;
    endfunction

    // The accept cycle already counts as busy so no lookup races the sweep.
    assign busy = (state_q != ST_IDLE) || flush_req;

    always_comb begin
        hit_way = '0;
        hit_w   = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_way[w] = req && req_cached && !busy && valid_q[w][idx]
                         && (tag_q[w][idx] == atag);
            if (hit_way[w]) hit_w = way_t'(w);
        end
    end

    assign hit  = |hit_way;
    assign miss = req && req_cached && !hit && !busy;

    always_comb begin
        logic match;
        way_t vb;
        any_inv  = 1'b0;
        vic_inv  = '0;
        vic_plru = '0;
        match    = 1'b0;
        vb       = '0;
        for (int v = WAYS - 1; v >= 0; v--)
            if (!valid_q[v][idx]) begin
                any_inv = 1'b1;
                vic_inv = way_t'(v);
            end
        for (int v = 0; v < WAYS; v++) begin
            match = 1'b1;
            vb    = way_t'(v);
            for (int l = 0; l < WAY_W; l++)
                if (plru_q[idx][(2 ** l) - 1 + (v >> (WAY_W - l))] != vb[WAY_W-1-l])
                    match = 1'b0;
            if (match) vic_plru = vb;
        end
        vic = any_inv ? vic_inv : vic_plru;
    end

    assign victim_way   = WAYS'(1) << vic;
    assign victim_dirty = valid_q[vic][idx] && dirty_q[vic][idx];
    assign victim_tag   = tag_q[vic][idx];

    assign refill_en = refill && !busy && !stall;
    assign hit_upd   = hit && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (state_q == ST_DONE) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            if (state_q == ST_WB && wb_ack) dirty_q[w_q][s_q] <= 1'b0;
            if (refill_en) begin
                valid_q[vic][idx] <= 1'b1;
                dirty_q[vic][idx] <= req_we;
                plru_q[idx]       <= plru_touch(plru_q[idx], vic);
            end else if (hit_upd) begin
                plru_q[idx] <= plru_touch(plru_q[idx], hit_w);
                if (req_we) dirty_q[hit_w][idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (refill_en) tag_q[vic][idx] <= atag;
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        w_d      = w_q;
        wb_req_d = wb_req_q;
        adv      = 1'b0;
        unique case (state_q)
            ST_IDLE:
                if (flush_req) begin
                    state_d = ST_SCAN;
                    s_d     = '0;
                    w_d     = '0;
                end
            ST_SCAN:
                if (valid_q[w_q][s_q] && dirty_q[w_q][s_q]) begin
                    state_d  = ST_WB;
                    wb_req_d = 1'b1;
                end else begin
                    adv = 1'b1;
                end
            ST_WB:
                if (wb_ack) begin
                    wb_req_d = 1'b0;
                    adv      = 1'b1;
                end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
            if (&s_q && &w_q) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_SCAN;
                w_d     = w_q + 1'b1;
                if (&w_q) begin
                    w_d = '0;
                    s_d = s_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            w_q      <= '0;
            wb_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            w_q      <= w_d;
            wb_req_q <= wb_req_d;
        end
    end

    assign wb_req  = wb_req_q;
    assign wb_addr = wb_req_q ? {tag_q[w_q][s_q], s_q, {OFFSET_W{1'b0}}} : '0;
    assign wb_way  = wb_req_q ? (WAYS'(1) << w_q) : '0;

`ifdef DCACHE_TAG_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
            perf_wb   <= '0;
        end else if (!stall) begin
            if (hit && perf_hit != '1) perf_hit <= perf_hit + 1'b1;
            if (miss && perf_miss != '1) perf_miss <= perf_miss + 1'b1;
            if (victim_dirty && refill_en && perf_wb != '1)
                perf_wb <= perf_wb + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(hit_way)) else $error("multiple ways hit");
            assert (!(refill && hit)) else $error("refill during hit");
        end
    end

endmodule
